// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Defining FIFO_PARITY_EN adds one even-parity bit to every stored word.
package fifo_pkg;

`ifdef FIFO_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic parity;
    } fifo_err_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// One wrap-around FIFO pointer (head or tail) with increment and clear.
// Wraps by compare-and-clear so non-power-of-two depths index correctly.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_inc,
    input  logic                    i_clr,
    output logic [ptr_w(DEPTH)-1:0] o_ptr
);

    localparam int            PW   = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    // Pointer register: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_param.sv
// Synchronous show-ahead FIFO with fill count, programmable almost flags,
// flush, sticky error flags and optional per-word parity (FIFO_PARITY_EN).
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        datain,
    input  logic                    pull,
    output logic [WIDTH-1:0]        dataout,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    err_clr
`ifdef FIFO_PARITY_EN
    ,
    output logic                    parity_err
`endif
);

    localparam int            CW      = cnt_w(DEPTH);
    localparam int            PW      = ptr_w(DEPTH);
    localparam int            MW      = WIDTH + PAR_W;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH) && (DEPTH >= 2))) begin : g_bad_params
        $error("fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH and DEPTH >= 2");
    end

    function automatic logic f_even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [MW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    w_head;
    logic [PW-1:0]    w_tail;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_af;
    logic             r_ae;
    fifo_err_t        r_err;
    fifo_err_t        w_err_nxt;
    logic             w_push_ok;
    logic             w_pull_ok;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_par_bad;
    logic [MW-1:0]    w_wr_word;
    logic [MW-1:0]    w_head_word;

    // A full FIFO still accepts a push when the same edge pulls a word out.
    assign w_push_ok = push && (!r_full || pull);
    assign w_pull_ok = pull && !r_empty;
    assign w_wr_en   = w_push_ok && !flush;
    assign w_rd_en   = w_pull_ok && !flush;
    assign w_ovf_set = push && r_full && !pull && !flush;
    assign w_unf_set = pull && r_empty && !flush;

    fifo_ptr #(.DEPTH(DEPTH)) u_head (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wr_en),
        .i_clr (flush),
        .o_ptr (w_head)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_rd_en),
        .i_clr (flush),
        .o_ptr (w_tail)
    );

    assign w_head_word = r_mem[w_tail];
    assign dataout     = w_head_word[WIDTH-1:0];

`ifdef FIFO_PARITY_EN
    assign w_wr_word  = {f_even_par(datain), datain};
    assign w_par_bad  = w_rd_en && (^w_head_word);
    assign parity_err = r_err.parity;
`else
    logic w_unused_par;
    assign w_wr_word    = datain;
    assign w_par_bad    = 1'b0;
    assign w_unused_par = r_err.parity;
`endif

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_head] <= w_wr_word;
        end
    end

    // Next fill level: flush wins, simultaneous accepted push and pull cancel.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_wr_en && !w_rd_en) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rd_en && !w_wr_en) begin
            w_count_nxt = r_count - CW'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Sticky error flags: a same-cycle set beats err_clr.
    always_comb begin
        w_err_nxt           = r_err;
        w_err_nxt.overflow  = (r_err.overflow  && !err_clr) || w_ovf_set;
        w_err_nxt.underflow = (r_err.underflow && !err_clr) || w_unf_set;
        w_err_nxt.parity    = (r_err.parity    && !err_clr) || w_par_bad;
    end

    // Count, status flags and error register, all derived from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= (AF_LEVEL == 0);
            r_ae    <= 1'b1;
            r_err   <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= C_AF);
            r_ae    <= (w_count_nxt <= C_AE);
            r_err   <= w_err_nxt;
        end
    end

    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign overflow     = r_err.overflow;
    assign underflow    = r_err.underflow;

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Next-generation synchronous FIFO with parametrised width and depth, including non-power-of-2 depths.
- Adds over the current FIFO:
  - fill count and programmable almost-full / almost-empty flags;
  - synchronous flush;
  - push-while-full when a pull occurs in the same cycle;
  - sticky overflow/underflow error flags.
- Sits between a producer and a consumer in UVM-benched datapaths, as a drop-in buffer.

Parameters:
- WIDTH, 32, data bus width in bits (1..1024)
- DEPTH, 32, number of entries (2..4096, any integer)
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- push  in  1  write request
- datain  in  WIDTH  write data
- pull  in  1  read request; consumes the word currently on dataout
- dataout  out  WIDTH  head-of-queue data, show-ahead
- flush  in  1  synchronous clear of contents
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH+1)  number of stored words
- overflow  out  1  sticky: push rejected
- underflow  out  1  sticky: pull on empty
- err_clr  in  1  clears overflow/underflow (and parity_err if present)

Behaviour:
- Clocking and reset
  - One clock, clk. Reset is asynchronous and active-high on rst.
  - Reset values: head = 0, tail = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (unless AF_LEVEL == 0), overflow = 0, underflow = 0.
  - dataout is undefined after reset until the first write; memory is not reset.
  - Reset mid-operation discards all contents immediately.
- Flags: full, empty, almost_*, count and dataout are all functions of registered state only (no input-to-output combinational paths).
- Show-ahead read: dataout = mem[tail] at all times. A pull in cycle N makes the next word visible after edge N.
- Write latency: a word pushed at edge N is visible on dataout after edge N when the FIFO was empty.
- Push acceptance: accepted when !full, OR when full && pull (pull removes a word the same edge).
- Pull acceptance: accepted when !empty. A pull when empty is ignored, even with a simultaneous push; the pushed word is stored.
- Count update: +1 if push accepted only; -1 if pull accepted only; unchanged if both or neither.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0. Use compare-and-clear, not power-of-2 masking.
- Flush:
  - Sets head = tail = count = 0 on the next edge.
  - Has priority over push/pull; a same-cycle push is discarded and no error is raised.
- Error flags:
  - overflow sets on push && full && !pull && !flush.
  - underflow sets on pull && empty && !flush.
  - Both hold until err_clr or rst. A same-cycle set wins over err_clr.
- Elaboration checks (assert): AE_LEVEL < AF_LEVEL <= DEPTH, and DEPTH >= 2.

Optional Feature:
- Macro: FIFO_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from datain at write.
  - On an accepted pull, parity of mem[tail] is checked; a mismatch sets sticky output parity_err (1 bit, reset 0, cleared by err_clr).
  - Data is still delivered unchanged.
- Not defined: no parity storage, and the parity_err port does not exist.

Decomposition:
- Package fifo_pkg:
  - function cnt_w(depth) returning $clog2(depth+1);
  - typedef fifo_err_t (packed struct: overflow, underflow, parity);
  - localparam PAR_W (1 or 0).
- Sub-module fifo_ptr (parameter DEPTH): holds one wrap-around pointer with inc/clr inputs. Instanced twice, for head and tail.
- Storage is an inferred register array in the top level.

Test Plan:
- Fill/drain, DEPTH=8, WIDTH=16:
  - push 0x0001..0x0008 -> full=1, count=8, almost_full from count=6;
  - then pull 8 times -> dataout 0x0001..0x0008 in order, empty=1, almost_empty at count<=2.
- Push+pull when full: count=8, push 0xAAAA with pull -> count stays 8, 0xAAAA emerges as the 8th subsequent read, overflow=0.
- Overflow/underflow:
  - push while full without pull -> overflow=1, count=8, data unchanged;
  - pull while empty -> underflow=1;
  - err_clr -> both 0.
- Non-power-of-2 wrap, DEPTH=5: stream 20 words with alternating push/pull bursts -> in-order data, head/tail wrap 4->0, count never exceeds 5.
- Flush and reset: count=3, flush with push -> count=0, empty=1, pushed word dropped. Assert rst mid-burst -> all flags return to reset values within the same cycle.
- Parity (FIFO_PARITY_EN): force-flip one stored bit via hierarchical deposit, pull that word -> parity_err=1, data delivered unchanged.
